// File: rtl/ring_pkg.sv
// Shared slot-type codes and field widths for the slotted message ring.
package ring_pkg;

  localparam int unsigned RING_DATA_W = 32;
  localparam int unsigned SLOT_TYPE_W = 4;
  localparam int unsigned SRC_DEST_W  = 4;
  localparam int unsigned TRAIN_LEN_W = 8;

  localparam logic [SLOT_TYPE_W-1:0] SLOT_TOKEN   = 4'd1;
  localparam logic [SLOT_TYPE_W-1:0] SLOT_MESSAGE = 4'd2;
  localparam logic [SLOT_TYPE_W-1:0] SLOT_LOCK    = 4'd3;
  localparam logic [SLOT_TYPE_W-1:0] SLOT_NULL    = 4'd7;
  localparam logic [SLOT_TYPE_W-1:0] SLOT_BARRIER = 4'd13;

  typedef enum logic [1:0] {
    TM_FLUSH,
    TM_INJECT,
    TM_WAIT_TOK,
    TM_PASS
  } tmState_t;

  function automatic logic [TRAIN_LEN_W-1:0] maxLen(input logic [TRAIN_LEN_W-1:0] a,
                                                    input logic [TRAIN_LEN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ring_watchdog.sv
// Token-loss watchdog: counts enabled cycles, flags the last one before timeout.
module ring_watchdog #(
  parameter int unsigned TOKEN_TMO = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = 16;

  logic [CW-1:0] tmoCnt;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      tmoCnt <= '0;
    end else if (en) begin
      tmoCnt <= tmoCnt + CW'(1);
    end
  end

  assign expire = (tmoCnt == CW'(TOKEN_TMO - 1));

endmodule

// File: rtl/ring_token_master.sv
// Ring-origin controller: flushes the ring, issues the single Token,
// absorbs it with its train, reissues it, and recovers lost/duplicate Tokens.
module ring_token_master
  import ring_pkg::*;
#(
  parameter int unsigned RING_LEN  = 16,
  parameter int unsigned TOKEN_TMO = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SRC_DEST_W-1:0]  whichCore,
  input  logic [RING_DATA_W-1:0] RingIn,
  input  logic [SLOT_TYPE_W-1:0] SlotTypeIn,
  input  logic [SRC_DEST_W-1:0]  SrcDestIn,
  output logic [RING_DATA_W-1:0] tmRingOut,
  output logic [SLOT_TYPE_W-1:0] tmSlotTypeOut,
  output logic [SRC_DEST_W-1:0]  tmSrcDestOut,
  output logic                   tmDriveRing,
  output logic                   tokenLost,
  output logic                   dupToken,
  output logic [31:0]            rounds,
  output logic [TRAIN_LEN_W-1:0] maxTrain
);

  localparam int unsigned FCW = (RING_LEN > 1) ? $clog2(RING_LEN) : 1;

  tmState_t               state;
  logic [FCW-1:0]         flushCnt;
  logic [TRAIN_LEN_W-1:0] len;
  logic                   isToken;
  logic [TRAIN_LEN_W-1:0] trainLen;
  logic                   expire;
  logic                   wdClr;
  logic                   wdEn;

  assign isToken  = (SlotTypeIn == SLOT_TOKEN);
  assign trainLen = RingIn[TRAIN_LEN_W-1:0];

  // Counter only runs while waiting; any Token or the timeout itself restarts it.
  assign wdEn  = (state == TM_WAIT_TOK);
  assign wdClr = (state != TM_WAIT_TOK) || isToken || expire;

  ring_watchdog #(
    .TOKEN_TMO(TOKEN_TMO)
  ) uWatchdog (
    .clock  (clock),
    .reset  (reset),
    .clr    (wdClr),
    .en     (wdEn),
    .expire (expire)
  );

  always_comb begin
    tmDriveRing   = 1'b0;
    tmRingOut     = RingIn;
    tmSlotTypeOut = SlotTypeIn;
    tmSrcDestOut  = SrcDestIn;
    tokenLost     = 1'b0;
    dupToken      = 1'b0;
    case (state)
      TM_FLUSH: begin
        tmDriveRing   = 1'b1;
        tmSlotTypeOut = SLOT_NULL;
        tmRingOut     = '0;
      end
      TM_INJECT: begin
        tmDriveRing   = 1'b1;
        tmSlotTypeOut = SLOT_TOKEN;
        tmRingOut     = '0;
        tmSrcDestOut  = whichCore;
      end
      TM_WAIT_TOK: begin
        if (isToken) begin
          tmDriveRing   = 1'b1;
          tmSlotTypeOut = SLOT_NULL;
          tmRingOut     = '0;
        end else if (expire) begin
          tokenLost = !reset;
        end
      end
      TM_PASS: begin
        if (isToken) begin
          tmDriveRing   = 1'b1;
          tmSlotTypeOut = SLOT_NULL;
          tmRingOut     = '0;
          dupToken      = !reset;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= TM_FLUSH;
      flushCnt <= '0;
      len      <= '0;
      rounds   <= '0;
      maxTrain <= '0;
    end else begin
      case (state)
        TM_FLUSH: begin
          if (flushCnt == FCW'(RING_LEN - 1)) begin
            state <= TM_INJECT;
          end else begin
            flushCnt <= flushCnt + FCW'(1);
          end
        end
        TM_INJECT: begin
          rounds <= rounds + 32'd1;
          state  <= TM_WAIT_TOK;
        end
        TM_WAIT_TOK: begin
          if (isToken) begin
            maxTrain <= maxLen(maxTrain, trainLen);
            if (trainLen == '0) begin
              state <= TM_INJECT;
            end else begin
              len   <= trainLen;
              state <= TM_PASS;
            end
          end else if (expire) begin
            flushCnt <= '0;
            state    <= TM_FLUSH;
          end
        end
        TM_PASS: begin
          if (len == TRAIN_LEN_W'(1)) begin
            state <= TM_INJECT;
          end else begin
            len <= len - TRAIN_LEN_W'(1);
          end
        end
        default: state <= TM_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_token_master.sv
// Scoreboard bench for ring_token_master: stimulus tasks push per-cycle expectations, a monitor checks them.
module tb_ring_token_master;
  import ring_pkg::*;

  localparam int unsigned RL  = 16;
  localparam int unsigned TMO = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  whichCore = '0;
  logic [31:0] RingIn = '0;
  logic [3:0]  SlotTypeIn = SLOT_NULL;
  logic [3:0]  SrcDestIn = '0;
  logic [31:0] tmRingOut;
  logic [3:0]  tmSlotTypeOut;
  logic [3:0]  tmSrcDestOut;
  logic        tmDriveRing;
  logic        tokenLost;
  logic        dupToken;
  logic [31:0] rounds;
  logic [7:0]  maxTrain;

  always #5 clock = ~clock;

  ring_token_master #(
    .RING_LEN (RL),
    .TOKEN_TMO(TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .whichCore    (whichCore),
    .RingIn       (RingIn),
    .SlotTypeIn   (SlotTypeIn),
    .SrcDestIn    (SrcDestIn),
    .tmRingOut    (tmRingOut),
    .tmSlotTypeOut(tmSlotTypeOut),
    .tmSrcDestOut (tmSrcDestOut),
    .tmDriveRing  (tmDriveRing),
    .tokenLost    (tokenLost),
    .dupToken     (dupToken),
    .rounds       (rounds),
    .maxTrain     (maxTrain)
  );

  typedef struct {
    string       tag;
    bit          chkDrive;
    bit          chkType;
    bit          chkData;
    bit          chkSd;
    bit          chkCnt;
    logic        drive;
    logic [3:0]  typ;
    logic [31:0] data;
    logic [3:0]  sd;
    logic        lost;
    logic        dup;
    logic [31:0] rounds;
    logic [7:0]  maxT;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] expRounds = '0;
  logic [7:0]  expMax = '0;

  function automatic exp_t mk(input string tag, input bit cd, input logic drv,
                              input bit ct, input logic [3:0] typ,
                              input bit cda, input logic [31:0] dat,
                              input bit cs, input logic [3:0] sd,
                              input logic lost, input logic dup, input bit cc);
    exp_t e;
    e.tag = tag; e.chkDrive = cd; e.drive = drv; e.chkType = ct; e.typ = typ;
    e.chkData = cda; e.data = dat; e.chkSd = cs; e.sd = sd;
    e.lost = lost; e.dup = dup; e.chkCnt = cc; e.rounds = '0; e.maxT = '0;
    return e;
  endfunction

  function automatic logic [3:0] rndType();
    logic [3:0] t;
    do t = 4'($urandom_range(0, 15)); while (t == SLOT_TOKEN);
    return t;
  endfunction

  // One ring cycle: drive the slot just after the edge and queue what must come out.
  task automatic step(input logic rst, input logic [3:0] t, input logic [31:0] d,
                      input logic [3:0] s, input exp_t e);
    @(posedge clock);
    #1;
    reset = rst; SlotTypeIn = t; RingIn = d; SrcDestIn = s;
    e.rounds = expRounds;
    e.maxT   = expMax;
    sb.push_back(e);
  endtask

  task automatic doReset(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step(1'b1, (i == 0) ? SLOT_TOKEN : rndType(), $urandom, 4'($urandom),
           mk("reset", 0, 0, 0, '0, 0, '0, 0, '0, 1'b0, 1'b0, 0));
    end
    expRounds = '0;
    expMax    = '0;
  endtask

  task automatic flush();
    logic [3:0] t, s;
    for (int unsigned i = 0; i < RL; i++) begin
      t = ($urandom_range(0, 3) == 0) ? SLOT_TOKEN : rndType();
      s = 4'($urandom);
      step(1'b0, t, $urandom, s, mk("flush", 1, 1'b1, 1, SLOT_NULL, 1, '0, 1, s, 1'b0, 1'b0, 1));
    end
  endtask

  task automatic inject();
    step(1'b0, rndType(), $urandom, 4'($urandom),
         mk("inject", 1, 1'b1, 1, SLOT_TOKEN, 1, '0, 1, whichCore, 1'b0, 1'b0, 1));
    expRounds = expRounds + 32'd1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step(1'b0, rndType(), $urandom, 4'($urandom),
           mk("wait", 1, 1'b0, 0, '0, 0, '0, 0, '0, 1'b0, 1'b0, 1));
    end
  endtask

  task automatic timeoutCycle();
    step(1'b0, rndType(), $urandom, 4'($urandom),
         mk("timeout", 1, 1'b0, 0, '0, 0, '0, 0, '0, 1'b1, 1'b0, 1));
  endtask

  task automatic tokenCycle(input logic [7:0] len);
    logic [31:0] d;
    d = {24'($urandom), len};
    step(1'b0, SLOT_TOKEN, d, 4'($urandom),
         mk("absorb", 1, 1'b1, 1, SLOT_NULL, 0, '0, 0, '0, 1'b0, 1'b0, 1));
    if (len > expMax) expMax = len;
  endtask

  task automatic train(input int unsigned n, input int unsigned dupPct);
    for (int unsigned i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < dupPct) begin
        step(1'b0, SLOT_TOKEN, $urandom, 4'($urandom),
             mk("dup", 1, 1'b1, 1, SLOT_NULL, 0, '0, 0, '0, 1'b0, 1'b1, 1));
      end else begin
        step(1'b0, rndType(), $urandom, 4'($urandom),
             mk("train", 1, 1'b0, 0, '0, 0, '0, 0, '0, 1'b0, 1'b0, 1));
      end
    end
  endtask

  task automatic round(input logic [7:0] len, input int unsigned dupPct);
    tokenCycle(len);
    train(int'(len), dupPct);
    inject();
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      bit   bad;
      e = sb.pop_front();
      checks++;
      bad = (tokenLost !== e.lost) || (dupToken !== e.dup)
         || (e.chkDrive && tmDriveRing !== e.drive)
         || (e.chkType && tmSlotTypeOut !== e.typ)
         || (e.chkData && tmRingOut !== e.data)
         || (e.chkSd && tmSrcDestOut !== e.sd)
         || (e.chkCnt && (rounds !== e.rounds || maxTrain !== e.maxT));
      if (bad) begin
        errors++;
        $display("FAIL %s @%0t: got drive=%b type=%0d data=%h sd=%0d lost=%b dup=%b rounds=%0d maxTrain=%0d; want drive=%b type=%0d data=%h sd=%0d lost=%b dup=%b rounds=%0d maxTrain=%0d",
                 e.tag, $time, tmDriveRing, tmSlotTypeOut, tmRingOut, tmSrcDestOut, tokenLost,
                 dupToken, rounds, maxTrain, e.drive, e.typ, e.data, e.sd, e.lost, e.dup,
                 e.rounds, e.maxT);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL time limit: simulation did not finish, %0d checks pending", sb.size());
    $fatal(1, "time limit");
  end

  initial begin
    whichCore = 4'($urandom);
    doReset(2);
    flush();
    inject();
    idle(5);
    round(8'd0, 0);
    round(8'd3, 0);
    idle(TMO - 1);
    timeoutCycle();
    flush();
    inject();
    idle(TMO - 1);
    round(8'd7, 0);
    round(8'd2, 100);
    round(8'd2, 50);
    round(8'd255, 5);
    idle(3);
    repeat (20) begin
      idle($urandom_range(0, 20));
      round(8'($urandom_range(0, 40)), 10);
    end
    tokenCycle(8'd5);
    train(2, 0);
    doReset(1);
    flush();
    inject();
    idle(4);
    round(8'd1, 0);
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
